store_buffer: RTL
=================

Name: store_buffer

Overview:
- In-order store buffer sitting directly upstream of mem_32, between the pipeline's memory stage and the data memory port.
- Queues stores (address, data, length) in a FIFO and drains one per cycle into mem_32 whenever the port is not serving a load.
- Loads read mem_32 combinationally and are stalled while any buffered store to the same 32-bit word is still pending.
- Uses mem_defs types (data_length_t, unsigned_t) for access length and sign.

Parameters:
- SIZE, 256, memory size in bytes; must match mem_32 SIZE.
- ADDR_BITS, $clog2(SIZE), byte-address width.
- DEPTH, 4, buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_req  in  1  store request.
- st_addr  in  ADDR_BITS  store byte address.
- st_data  in  32  store data, right-aligned.
- st_mode  in  data_length_t  store length (LEN_BYTE/LEN_HALF/LEN_WORD).
- st_ready  out  1  store accepted this cycle if st_req is high.
- ld_req  in  1  load request.
- ld_addr  in  ADDR_BITS  load byte address.
- ld_mode  in  data_length_t  load length.
- ld_sign  in  unsigned_t  load sign mode (SIG/UNSIG).
- ld_valid  out  1  ld_data valid this cycle; load complete.
- ld_data  out  32  load result, taken from mem_data_out.
- mem_addr  out  ADDR_BITS  to mem_32 addr.
- mem_wdata  out  32  to mem_32 data_in.
- mem_rdata  in  32  from mem_32 data_out.
- mem_wr  out  1  to mem_32 wr.
- mem_access_mode  out  data_length_t  to mem_32 access_mode.
- mem_sign_mode  out  unsigned_t  to mem_32 sign_mode.
- count  out  $clog2(DEPTH)+1  occupied entries.
- empty  out  1  count == 0.

Behaviour:
Reset
- Asynchronous; the buffer is emptied and pending stores are discarded, including on reset mid-drain.
- During and after reset: count=0, empty=1, st_ready=1, mem_wr=0, ld_valid=0.
- mem_addr, mem_wdata, ld_data = 0; mem_access_mode=LEN_WORD; mem_sign_mode=UNSIG.

Storage
- Circular FIFO with head/tail pointers that wrap modulo DEPTH.
- Each entry holds {addr, data, mode}.

Enqueue
- st_ready = (count != DEPTH); it does not depend on a same-cycle drain.
- st_req & st_ready: entry written at tail on the clock edge.
- st_req while full: nothing is written and the request must be held.

Hazard
- hit = any valid entry with entry.addr[ADDR_BITS-1:2] == ld_addr[ADDR_BITS-1:2]. This is a conservative word match that ignores length.
- Entries enqueued in the current cycle are excluded, because the load is older.

Port arbitration (combinational, per cycle)
- LOAD: ld_req & !hit & (count != DEPTH).
  - mem_addr=ld_addr, mem_access_mode=ld_mode, mem_sign_mode=ld_sign, mem_wr=0.
  - ld_valid=1, ld_data=mem_rdata in the same cycle (zero latency).
- DRAIN: otherwise, if count != 0.
  - mem_addr/mem_wdata/mem_access_mode come from the head entry; mem_sign_mode=UNSIG; mem_wr=1.
  - Head advances at the edge, so a store reaches memory 1 cycle after it is enqueued at the earliest.
- IDLE: otherwise mem_wr=0, ld_valid=0, and the port holds its previous address/mode.
- A full buffer gives DRAIN priority over loads (no starvation). A load stalled on a hazard sees the drain proceed every cycle, so the hazard clears in at most DEPTH cycles.
- ld_valid=0 whenever ld_req is stalled; the requester holds ld_* stable.

Counters and simultaneity
- count updates by +1 (enqueue), -1 (drain) or 0 (both or neither).
- Enqueue and drain in the same cycle with count=DEPTH cannot occur, because st_ready=0 when full.
- Enqueue into an empty buffer does not drain in the same cycle.

Test Plan:
- Reset mid-run: enqueue 3 stores, assert rst for 3 ns between edges. Required: count=0, empty=1 and mem_wr=0 immediately; no further mem_wr pulses.
- Store then drain: st_addr=0x10, st_data=0x13370000, LEN_WORD, no loads. Required: count=1 next cycle; the following cycle mem_wr=1, mem_addr=0x10, mem_wdata=0x13370000; then empty=1.
- Fill/full: 5 back-to-back stores with ld_req=1 to an unrelated address (0x80), DEPTH=4. Required: loads win while count<4; at count=4 st_ready=0 and DRAIN overrides the load; the 5th store is accepted once count drops to 3.
- Load hazard: store 0x000fab10 LEN_HALF to 0x02, then the next cycle load LEN_HALF SIG from 0x00 (same word). Required: ld_valid=0 until the entry drains, then ld_valid=1 with ld_data equal to mem_rdata for addr 0x00.
- No hazard: buffered store to 0x10, load LEN_WORD UNSIG from 0x00. Required: ld_valid=1 in the request cycle, mem_wr=0, and the drain is deferred one cycle.
- Wrap-around: 10 stores to addresses 0x00..0x24 (step 4) with data equal to address. Required: mem_wr sequence is in exact order with matching data, pointers wrap correctly, and count returns to 0.

Source files
------------

// File: rtl/mem_defs.sv
// Shared access-length and sign types for the data memory path.
package mem_defs;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'b00,
        LEN_HALF = 2'b01,
        LEN_WORD = 2'b10
    } data_length_t;

    typedef enum logic {
        UNSIG = 1'b0,
        SIG   = 1'b1
    } unsigned_t;

endpackage

// File: rtl/store_buffer.sv
// In-order store buffer in front of mem_32. Stores queue in a small circular
// FIFO and drain one per cycle whenever the memory port is not serving a load.
// Loads access the port combinationally. They stall while a buffered store to
// the same 32-bit word is still pending.
module store_buffer
    import mem_defs::*;
#(
    parameter int SIZE      = 256,
    parameter int ADDR_BITS = $clog2(SIZE),
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_req,
    input  logic [ADDR_BITS-1:0]       st_addr,
    input  logic [31:0]                st_data,
    input  data_length_t               st_mode,
    output logic                       st_ready,
    input  logic                       ld_req,
    input  logic [ADDR_BITS-1:0]       ld_addr,
    input  data_length_t               ld_mode,
    input  unsigned_t                  ld_sign,
    output logic                       ld_valid,
    output logic [31:0]                ld_data,
    output logic [ADDR_BITS-1:0]       mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata,
    output logic                       mem_wr,
    output data_length_t               mem_access_mode,
    output unsigned_t                  mem_sign_mode,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; contents are only meaningful between head and tail.
    logic [ADDR_BITS-1:0] ent_addr_q [DEPTH];
    logic [31:0]          ent_data_q [DEPTH];
    data_length_t         ent_mode_q [DEPTH];

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    // Last port drive, replayed while the port is idle.
    logic [ADDR_BITS-1:0] port_addr_q, port_addr_d;
    logic [31:0]          port_wdata_q, port_wdata_d;
    data_length_t         port_mode_q, port_mode_d;
    unsigned_t            port_sign_q, port_sign_d;

    logic                 full;
    logic                 enq;
    logic                 do_load;
    logic                 do_drain;
    logic                 hit;
    logic [DEPTH-1:0]     hit_vec;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign st_ready = !full;
    assign enq      = st_req && !full;
    assign count    = count_q;
    assign empty    = (count_q == '0);

    // Word-granular hazard match against every occupied entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [PTR_W-1:0] offs;
        assign offs        = PTR_W'(gi) - head_q;
        assign hit_vec[gi] = ({1'b0, offs} < count_q) &&
                             (ent_addr_q[gi][ADDR_BITS-1:2] == ld_addr[ADDR_BITS-1:2]);
    end
    assign hit = |hit_vec;

    // Port arbitration: load first unless hazard or full, else drain head, else idle.
    always_comb begin
        do_load         = 1'b0;
        do_drain        = 1'b0;
        mem_addr        = port_addr_q;
        mem_wdata       = port_wdata_q;
        mem_access_mode = port_mode_q;
        mem_sign_mode   = port_sign_q;
        mem_wr          = 1'b0;
        ld_valid        = 1'b0;
        ld_data         = 32'h0;
        if (!rst) begin
            if (ld_req && !hit && !full) begin
                do_load = 1'b1;
            end else if (count_q != '0) begin
                do_drain = 1'b1;
            end
        end
        if (do_load) begin
            mem_addr        = ld_addr;
            mem_access_mode = ld_mode;
            mem_sign_mode   = ld_sign;
            ld_valid        = 1'b1;
            ld_data         = mem_rdata;
        end else if (do_drain) begin
            mem_addr        = ent_addr_q[head_q];
            mem_wdata       = ent_data_q[head_q];
            mem_access_mode = ent_mode_q[head_q];
            mem_sign_mode   = UNSIG;
            mem_wr          = 1'b1;
        end
        port_addr_d  = mem_addr;
        port_wdata_d = mem_wdata;
        port_mode_d  = mem_access_mode;
        port_sign_d  = mem_sign_mode;
    end

    // Pointer and occupancy next state.
    always_comb begin
        head_d  = head_q + PTR_W'(do_drain);
        tail_d  = tail_q + PTR_W'(enq);
        count_d = count_q + CNT_W'(enq) - CNT_W'(do_drain);
    end

    // Control and port-hold registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            port_addr_q  <= '0;
            port_wdata_q <= 32'h0;
            port_mode_q  <= LEN_WORD;
            port_sign_q  <= UNSIG;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            port_addr_q  <= port_addr_d;
            port_wdata_q <= port_wdata_d;
            port_mode_q  <= port_mode_d;
            port_sign_q  <= port_sign_d;
        end
    end

    // Entry write at tail; no reset needed since occupancy gates every use.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr_q[tail_q] <= st_addr;
            ent_data_q[tail_q] <= st_data;
            ent_mode_q[tail_q] <= st_mode;
        end
    end

endmodule
